uart_frame_packer: RTL and testbench

//  Packs one MPU6050 sample (accel X/Y/Z, gyro X/Y/Z) into a byte frame: header, payload, optional checksum.

---
 rtl/uart_pkg.sv | 17 +
 rtl/frame_checksum.sv | 31 +++
 rtl/uart_frame_packer.sv | 142 ++++++++++++++
 tb/tb_uart_frame_packer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame packer: one-hot FSM encodings, default header byte,
// and the frame-length helper. Optional checksum is controlled by UART_FRAME_CHECKSUM_EN.
package uart_pkg;

    localparam logic [3:0] ST_IDLE     = 4'b0001;
    localparam logic [3:0] ST_HEADER   = 4'b0010;
    localparam logic [3:0] ST_PAYLOAD  = 4'b0100;
    localparam logic [3:0] ST_CHECKSUM = 4'b1000;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'h55;

    // Total bytes in one frame: header, payload, and the checksum byte when enabled.
    function automatic int frame_len(input int num_words, input int word_bytes, input bit cks_en);
        return 1 + num_words * word_bytes + (cks_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/frame_checksum.sv
// Running modulo-2^DATA_WIDTH byte sum for the frame packer; used only when
// UART_FRAME_CHECKSUM_EN is defined.
module frame_checksum #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  add_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH-1:0] sum_r;

    // Accumulate every written byte; cleared at the start of each frame.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sum_r <= {DATA_WIDTH{1'b0}};
        end else if (clr) begin
            sum_r <= {DATA_WIDTH{1'b0}};
        end else if (add_en) begin
            sum_r <= sum_r + data;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/uart_frame_packer.sv
// Packs one captured sensor sample into header + big-endian payload (+ checksum when
// UART_FRAME_CHECKSUM_EN is defined) and writes it byte by byte into the TX FIFO.
module uart_frame_packer
    import uart_pkg::*;
#(
    parameter int                    NUM_WORDS   = 6,
    parameter int                    WORD_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
    input  logic                            clk_in,
    input  logic                            rst_n,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] sample_in,
    input  logic                            sample_vld_in,
    input  logic                            fifo_full_in,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic                            busy_out,
    output logic                            frame_done_out,
    output logic                            overrun_out
);

    localparam int WORD_BYTES = WORD_WIDTH / DATA_WIDTH;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif
    localparam int FRAME_LEN     = frame_len(NUM_WORDS, WORD_BYTES, CKS_EN);
    localparam int PAYLOAD_BYTES = FRAME_LEN - 1 - (CKS_EN ? 1 : 0);
    localparam int CNT_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);

    logic [3:0]                      state_r;
    logic [CNT_W-1:0]                byte_cnt_r;
    logic [NUM_WORDS*WORD_WIDTH-1:0] hold_r;
    logic                            wr_en_s;
    logic                            last_byte_s;
    logic                            busy_s;
    logic [DATA_WIDTH-1:0]           payload_byte_s;
    logic [DATA_WIDTH-1:0]           wr_data_s;
    logic [DATA_WIDTH-1:0]           cks_sum_s;

    assign busy_s      = (state_r != ST_IDLE);
    assign wr_en_s     = busy_s && !fifo_full_in;
    assign last_byte_s = (byte_cnt_r == LAST_BYTE);

    // Payload byte k is word k/WORD_BYTES, most significant byte of each word first.
    always_comb begin
        payload_byte_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            payload_byte_s = payload_byte_s |
                ({DATA_WIDTH{byte_cnt_r == CNT_W'(k)}} &
                 hold_r[(k / WORD_BYTES) * WORD_WIDTH +
                        (WORD_BYTES - 1 - (k % WORD_BYTES)) * DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Byte presented to the FIFO, derived purely from registered state.
    always_comb begin
        case (state_r)
            ST_HEADER:   wr_data_s = HEADER_BYTE;
            ST_PAYLOAD:  wr_data_s = payload_byte_s;
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CHECKSUM: wr_data_s = cks_sum_s;
`endif
            default:     wr_data_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Frame sequencer; state and byte counter only move on an accepted FIFO write.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= {CNT_W{1'b0}};
            hold_r     <= {(NUM_WORDS*WORD_WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    byte_cnt_r <= {CNT_W{1'b0}};
                    if (sample_vld_in) begin
                        hold_r  <= sample_in;
                        state_r <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (wr_en_s) begin
                        state_r <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (wr_en_s) begin
                        if (last_byte_s) begin
                            byte_cnt_r <= {CNT_W{1'b0}};
`ifdef UART_FRAME_CHECKSUM_EN
                            state_r    <= ST_CHECKSUM;
`else
                            state_r    <= ST_IDLE;
`endif
                        end else begin
                            byte_cnt_r <= byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
`ifdef UART_FRAME_CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (wr_en_s) begin
                        state_r <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_r    <= ST_IDLE;
                    byte_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    frame_checksum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_frame_checksum (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    ((state_r == ST_IDLE) && sample_vld_in),
        .add_en (wr_en_s && (state_r != ST_CHECKSUM)),
        .data   (wr_data_s),
        .sum    (cks_sum_s)
    );
    assign frame_done_out = wr_en_s && (state_r == ST_CHECKSUM);
`else
    assign cks_sum_s      = {DATA_WIDTH{1'b0}};
    assign frame_done_out = wr_en_s && (state_r == ST_PAYLOAD) && last_byte_s;
`endif

    assign fifo_wr_en   = wr_en_s;
    assign fifo_wr_data = wr_data_s;
    assign busy_out     = busy_s;
    assign overrun_out  = sample_vld_in && busy_s;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Self-checking bench for uart_frame_packer: table-driven frames with back-pressure plus
// hand sequences for overrun, mid-frame reset and back-to-back samples.
module tb_uart_frame_packer;

`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CKS  = 1'b1;
    localparam int FLEN = 14;
`else
    localparam bit CKS  = 1'b0;
    localparam int FLEN = 13;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] sample_in;
    logic        sample_vld_in;
    logic        fifo_full_in;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        busy_out;
    logic        frame_done_out;
    logic        overrun_out;

    uart_frame_packer dut (
        .clk_in         (clk),
        .rst_n          (rst_n),
        .sample_in      (sample_in),
        .sample_vld_in  (sample_vld_in),
        .fifo_full_in   (fifo_full_in),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [95:0] sample;
        int          stall_after;
        int          stall_len;
        logic [7:0]  exp_hold;
        logic [7:0]  exp_cks;
        logic [7:0]  exp_last_payload;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[3];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    int cyc_cnt  = 0;
    int wr_count = 0;
    int done_count = 0;
    int ov_count = 0;
    int last_cycles = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected byte stream for one sample: header, big-endian words 0..5, optional checksum.
    function automatic void push_frame(input logic [95:0] s);
        logic [7:0] cks;
        logic [7:0] b;
        cks = 8'h55;
        exp_q.push_back('{data: 8'h55, last: 1'b0});
        for (int w = 0; w < 6; w++) begin
            for (int h = 1; h >= 0; h--) begin
                b = s[w*16 + h*8 +: 8];
                cks = cks + b;
                exp_q.push_back('{data: b, last: (!CKS && w == 5 && h == 0)});
            end
        end
        if (CKS) begin
            exp_q.push_back('{data: cks, last: 1'b1});
        end
    endfunction

    // Scoreboard monitor: every FIFO write is popped from the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (busy_out === 1'b1) cyc_cnt++;
            else cyc_cnt = 0;
            if (overrun_out === 1'b1) ov_count++;
            if (fifo_full_in) check("no_write_when_full", {31'd0, fifo_wr_en}, 32'd0);
            if (fifo_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %0h, expected no write", fifo_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {24'd0, fifo_wr_data}, {24'd0, e.data});
                    check("frame_done", {31'd0, frame_done_out}, {31'd0, e.last});
                    wr_count++;
                    if (e.last) wr_count = 0;
                    if (frame_done_out === 1'b1) begin
                        done_count++;
                        last_byte   = fifo_wr_data;
                        last_cycles = cyc_cnt;
                    end
                end
            end else if (frame_done_out === 1'b1) begin
                check("done_without_write", 32'd1, 32'd0);
            end
        end
    end

    task automatic send_start(input logic [95:0] s);
        @(posedge clk); #1;
        sample_in = s;
        sample_vld_in = 1'b1;
        push_frame(s);
        @(posedge clk); #1;
        sample_vld_in = 1'b0;
        sample_in = ~s;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 200;
        do begin
            @(negedge clk);
            budget--;
        end while (busy_out !== 1'b0 && budget > 0);
        check("idle_timeout", {31'd0, budget > 0}, 32'd1);
    endtask

    task automatic wait_wr_count(input int target);
        int budget;
        budget = 100;
        while (wr_count != target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("wr_count_timeout", {31'd0, budget > 0}, 32'd1);
    endtask

    task automatic run_vector(input vec_t v);
        int done_before;
        done_before = done_count;
        send_start(v.sample);
        @(negedge clk);
        check("hdr_latency_wr_en", {31'd0, fifo_wr_en}, 32'd1);
        check("hdr_latency_data", {24'd0, fifo_wr_data}, 32'h55);
        if (v.stall_len > 0) begin
            @(posedge clk); #1;
            wait_wr_count(v.stall_after);
            fifo_full_in = 1'b1;
            repeat (v.stall_len) begin
                @(negedge clk);
                check("stall_wr_en", {31'd0, fifo_wr_en}, 32'd0);
                check("stall_hold", {24'd0, fifo_wr_data}, {24'd0, v.exp_hold});
                @(posedge clk); #1;
            end
            fifo_full_in = 1'b0;
        end
        wait_idle();
        check("frame_cycles", last_cycles, FLEN + v.stall_len);
        check("last_byte", {24'd0, last_byte}, {24'd0, CKS ? v.exp_cks : v.exp_last_payload});
        check("done_count", done_count, done_before + 1);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int done_before;
        int ov_before;
        vecs[0] = '{sample: {16'h0B0C, 16'h090A, 16'h0708, 16'h0506, 16'h0304, 16'h0102},
                    stall_after: 0, stall_len: 0, exp_hold: 8'h00, exp_cks: 8'hA3, exp_last_payload: 8'h0C};
        vecs[1] = '{sample: {16'h0B0C, 16'h090A, 16'h0708, 16'h0506, 16'h0304, 16'h0102},
                    stall_after: 3, stall_len: 5, exp_hold: 8'h03, exp_cks: 8'hA3, exp_last_payload: 8'h0C};
        vecs[2] = '{sample: {16'h5A5A, 16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'hFFFF},
                    stall_after: 12, stall_len: 3, exp_hold: 8'h5A, exp_cks: 8'hD0, exp_last_payload: 8'h5A};

        rst_n = 1'b0;
        sample_in = 96'd0;
        sample_vld_in = 1'b0;
        fifo_full_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_wr_data", {24'd0, fifo_wr_data}, 32'd0);
        check("rst_done", {31'd0, frame_done_out}, 32'd0);
        check("rst_overrun", {31'd0, overrun_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run_vector(vecs[i]);
        end

        // Overrun: second strobe four cycles after the first is dropped.
        ov_before = ov_count;
        done_before = done_count;
        send_start(vecs[0].sample);
        repeat (3) begin
            @(posedge clk); #1;
        end
        sample_vld_in = 1'b1;
        sample_in = vecs[2].sample;
        @(negedge clk);
        check("overrun_pulse", {31'd0, overrun_out}, 32'd1);
        @(posedge clk); #1;
        sample_vld_in = 1'b0;
        @(negedge clk);
        check("overrun_single", {31'd0, overrun_out}, 32'd0);
        wait_idle();
        repeat (20) @(negedge clk);
        check("overrun_count", ov_count, ov_before + 1);
        check("overrun_one_frame", done_count, done_before + 1);
        check("overrun_queue_empty", exp_q.size(), 32'd0);

        // Reset while payload byte 0x05 is presented abandons the frame.
        done_before = done_count;
        send_start(vecs[0].sample);
        wait_wr_count(5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        wr_count = 0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy_out}, 32'd0);
        check("mid_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("mid_rst_done", {31'd0, frame_done_out}, 32'd0);
        check("mid_rst_no_completion", done_count, done_before);
        run_vector(vecs[0]);

        // Strobe in the done cycle overruns; strobe one cycle later starts a new frame.
        ov_before = ov_count;
        done_before = done_count;
        send_start(vecs[0].sample);
        wait_wr_count(FLEN - 1);
        sample_vld_in = 1'b1;
        sample_in = ~vecs[2].sample;
        @(negedge clk);
        check("b2b_done", {31'd0, frame_done_out}, 32'd1);
        check("b2b_overrun", {31'd0, overrun_out}, 32'd1);
        @(posedge clk); #1;
        sample_in = vecs[2].sample;
        push_frame(vecs[2].sample);
        @(negedge clk);
        check("b2b_gap_idle", {31'd0, busy_out}, 32'd0);
        check("b2b_gap_no_overrun", {31'd0, overrun_out}, 32'd0);
        @(posedge clk); #1;
        sample_vld_in = 1'b0;
        sample_in = 96'd0;
        @(negedge clk);
        check("b2b_hdr_wr_en", {31'd0, fifo_wr_en}, 32'd1);
        check("b2b_hdr_data", {24'd0, fifo_wr_data}, 32'h55);
        wait_idle();
        check("b2b_done_count", done_count, done_before + 2);
        check("b2b_overrun_count", ov_count, ov_before + 1);
        check("b2b_last_byte", {24'd0, last_byte}, {24'd0, CKS ? vecs[2].exp_cks : vecs[2].exp_last_payload});
        check("b2b_queue_empty", exp_q.size(), 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
